// File: rtl/mvb_frame_tx.sv
// MVB frame transmitter: pulls 16-bit words and emits SD, data, CRC/parity check sequences and ED as Manchester half-bits.
// Optional build macro MVB_TX_GAP_EN adds a GAP_BITS-long idle gap after ED before done.
module mvb_frame_tx #(
    parameter int CLK_DIV   = 8,
    parameter int MAX_WORDS = 16,
    parameter int LEN_W     = 5,
    parameter int CS_WORDS  = 4
`ifdef MVB_TX_GAP_EN
   ,parameter int GAP_BITS  = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             master,
    input  logic [LEN_W-1:0] len_words,
    input  logic [15:0]      word_data,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             line_out,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GRP_W = $clog2(CS_WORDS + 1);

    localparam logic [17:0] SD_MASTER = 18'b10_11_00_01_11_00_10_10_10;
    localparam logic [17:0] SD_SLAVE  = 18'b10_10_10_10_11_00_01_11_00;

    localparam logic [7:0] LAST_SD   = 8'd17;
    localparam logic [7:0] LAST_DATA = 8'd31;
    localparam logic [7:0] LAST_CS   = 8'd15;
    localparam logic [7:0] LAST_ED   = 8'd1;
`ifdef MVB_TX_GAP_EN
    localparam logic [7:0] LAST_GAP  = 8'(2 * GAP_BITS - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SD,
        ST_DATA,
        ST_CS,
        ST_ED
`ifdef MVB_TX_GAP_EN
       ,ST_GAP
`endif
    } state_t;

    // x^7+x^6+x^5+x^2+1, MSB-first, one full word per call
    function automatic logic [6:0] crc7_word(input logic [6:0] crc_in, input logic [15:0] d);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ ({7{fb}} & 7'h65);
        end
        return c;
    endfunction

    function automatic logic [7:0] cs_byte(input logic [6:0] crc, input logic data_par);
        return {crc, data_par ^ (^crc)};
    endfunction

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [7:0]         r_hidx;
    logic [16:0]        r_sd;
    logic [15:0]        r_shift;
    logic [6:0]         r_crc;
    logic               r_par;
    logic [LEN_W-1:0]   r_words_left;
    logic [GRP_W-1:0]   r_grp;
    logic               r_line;
    logic               r_tx_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err_len;
    logic               r_err_underrun;

    logic               w_tick;
    logic               w_last_half;
    logic               w_to_cs;
    logic               w_fetch;
    logic               w_len_ok;
    logic [17:0]        w_sd_pat;
    logic [7:0]         w_cs_byte;

    assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_to_cs   = (r_grp == GRP_W'(CS_WORDS - 1)) || (r_words_left == '0);
    assign w_sd_pat  = master ? SD_MASTER : SD_SLAVE;
    assign w_cs_byte = cs_byte(r_crc, r_par);
    assign w_len_ok  = master ? (len_words == LEN_W'(1))
                              : ((len_words != '0) && (len_words <= LEN_W'(MAX_WORDS)));

    always_comb begin
        w_last_half = 1'b0;
        case (r_state)
            ST_SD:   w_last_half = (r_hidx == LAST_SD);
            ST_DATA: w_last_half = (r_hidx == LAST_DATA);
            ST_CS:   w_last_half = (r_hidx == LAST_CS);
            ST_ED:   w_last_half = (r_hidx == LAST_ED);
`ifdef MVB_TX_GAP_EN
            ST_GAP:  w_last_half = (r_hidx == LAST_GAP);
`endif
            default: w_last_half = 1'b0;
        endcase
    end

    // A word is pulled at the very last clk of SD, of a word that continues without CS, or of a CS with words pending.
    assign w_fetch = w_tick && w_last_half &&
                     ((r_state == ST_SD) ||
                      ((r_state == ST_DATA) && !w_to_cs) ||
                      ((r_state == ST_CS) && (r_words_left != '0)));

    assign word_ready = w_fetch && word_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_div          <= '0;
            r_hidx         <= '0;
            r_words_left   <= '0;
            r_grp          <= '0;
            r_line         <= 1'b0;
            r_tx_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_len      <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_err_len      <= 1'b0;
            r_err_underrun <= 1'b0;
            r_div          <= w_tick ? '0 : r_div + DIV_W'(1);

            if (r_state == ST_IDLE) begin
                r_div <= '0;
                if (start) begin
                    if (w_len_ok) begin
                        r_state      <= ST_SD;
                        r_hidx       <= '0;
                        r_sd         <= w_sd_pat[16:0];
                        r_line       <= w_sd_pat[17];
                        r_tx_en      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_words_left <= len_words;
                        r_grp        <= '0;
                        r_crc        <= '0;
                        r_par        <= 1'b0;
                    end else begin
                        r_err_len <= 1'b1;
                    end
                end
            end else if (w_fetch) begin
                if (word_valid) begin
                    r_state      <= ST_DATA;
                    r_hidx       <= '0;
                    r_shift      <= word_data;
                    r_line       <= word_data[15];
                    r_crc        <= crc7_word(r_crc, word_data);
                    r_par        <= r_par ^ (^word_data);
                    r_words_left <= r_words_left - LEN_W'(1);
                    if (r_state == ST_DATA)
                        r_grp <= r_grp + GRP_W'(1);
                end else begin
                    r_state        <= ST_IDLE;
                    r_div          <= '0;
                    r_line         <= 1'b0;
                    r_tx_en        <= 1'b0;
                    r_busy         <= 1'b0;
                    r_err_underrun <= 1'b1;
                end
            end else if (w_tick) begin
                if (!w_last_half) begin
                    r_hidx <= r_hidx + 8'd1;
                    case (r_state)
                        ST_SD: begin
                            r_sd   <= {r_sd[15:0], 1'b0};
                            r_line <= r_sd[16];
                        end
                        ST_DATA, ST_CS: begin
                            if (!r_hidx[0]) begin
                                r_line <= ~r_shift[15];
                            end else begin
                                r_shift <= {r_shift[14:0], 1'b0};
                                r_line  <= r_shift[14];
                            end
                        end
                        default: r_line <= 1'b0;
                    endcase
                end else begin
                    r_hidx <= '0;
                    case (r_state)
                        ST_DATA: begin
                            r_state <= ST_CS;
                            r_shift <= {w_cs_byte, 8'h00};
                            r_line  <= w_cs_byte[7];
                            r_crc   <= '0;
                            r_par   <= 1'b0;
                            r_grp   <= '0;
                        end
                        ST_CS: begin
                            r_state <= ST_ED;
                            r_line  <= 1'b0;
                        end
`ifdef MVB_TX_GAP_EN
                        ST_ED: begin
                            r_state <= ST_GAP;
                            r_line  <= 1'b0;
                            r_tx_en <= 1'b0;
                        end
                        ST_GAP: begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`else
                        ST_ED: begin
                            r_state <= ST_IDLE;
                            r_line  <= 1'b0;
                            r_tx_en <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
`endif
                        default: begin
                            r_state <= ST_IDLE;
                            r_line  <= 1'b0;
                            r_tx_en <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign line_out     = r_line;
    assign tx_en        = r_tx_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_len      = r_err_len;
    assign err_underrun = r_err_underrun;

endmodule

// File: tb/tb_mvb_frame_tx.sv
// Directed bench for mvb_frame_tx: one instance at CLK_DIV=8 and one at CLK_DIV=4, selected by sel4.
module tb_mvb_frame_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, master, word_valid, sel4;
    logic [4:0] len_words;
    logic [15:0] word_data;
    logic       start8, start4;
    logic       rdy8, line8, tx8, busy8, done8, elen8, eund8;
    logic       rdy4, line4, tx4, busy4, done4, elen4, eund4;
    logic       m_rdy, m_line, m_tx, m_busy, m_done, m_elen, m_eund;

    assign start8 = start & ~sel4;
    assign start4 = start & sel4;
    assign m_rdy  = sel4 ? rdy4  : rdy8;
    assign m_line = sel4 ? line4 : line8;
    assign m_tx   = sel4 ? tx4   : tx8;
    assign m_busy = sel4 ? busy4 : busy8;
    assign m_done = sel4 ? done4 : done8;
    assign m_elen = sel4 ? elen4 : elen8;
    assign m_eund = sel4 ? eund4 : eund8;

    mvb_frame_tx #(.CLK_DIV(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .master(master), .len_words(len_words),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy8),
        .line_out(line8), .tx_en(tx8), .busy(busy8), .done(done8),
        .err_len(elen8), .err_underrun(eund8)
    );

    mvb_frame_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .master(master), .len_words(len_words),
        .word_data(word_data), .word_valid(word_valid), .word_ready(rdy4),
        .line_out(line4), .tx_en(tx4), .busy(busy4), .done(done4),
        .err_len(elen4), .err_underrun(eund4)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] src [0:15];
    int   div;
    logic cap [$];
    logic hv [$];
    logic eh [$];
    int   rdy_cnt, done_cnt, und_cnt, tx_cycles;
    bit   timeout, stable;
    logic und_tx, und_line, end_line;

    task automatic pulse_start(input logic m, input logic [4:0] len);
        @(posedge clk); #1;
        master = m; len_words = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one frame, feeding src[] on word_ready, and records the line while tx_en is high.
    task automatic run_frame(input logic m, input logic [4:0] len, input int avail);
        int   idx;
        logic rdy;
        bit   finished;
        cap.delete();
        rdy_cnt = 0; done_cnt = 0; und_cnt = 0; tx_cycles = 0;
        und_tx = 1'bx; und_line = 1'bx; end_line = 1'bx;
        timeout = 1'b0; finished = 1'b0;
        idx = 0;
        word_data  = src[0];
        word_valid = (avail > 0);
        pulse_start(m, len);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (m_tx) begin
                cap.push_back(m_line);
                tx_cycles++;
            end
            rdy = m_rdy;
            if (m_rdy)  rdy_cnt++;
            if (m_done) done_cnt++;
            if (m_eund) begin
                und_cnt++;
                und_tx   = m_tx;
                und_line = m_line;
            end
            if (!m_busy) begin
                end_line = m_line;
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rdy) begin
                idx++;
                if (idx < 16) word_data = src[idx];
                word_valid = (idx < avail);
            end
        end
        if (!finished) timeout = 1'b1;
        word_valid = 1'b0;
    endtask

    task automatic decode();
        int   nh;
        logic v;
        hv.delete();
        stable = (cap.size() % div) == 0;
        nh = cap.size() / div;
        for (int h = 0; h < nh; h++) begin
            v = cap[h * div + div / 2];
            for (int j = 0; j < div; j++)
                if (cap[h * div + j] !== v) stable = 1'b0;
            hv.push_back(v);
        end
    endtask

    task automatic exp_bit(input logic b);
        eh.push_back(b);
        eh.push_back(~b);
    endtask

    // Reference CS: long division of the block bits (plus 7 zero bits) by 1_1100101, then even-ones parity.
    function automatic logic [7:0] model_cs(input int first, input int n);
        logic [7:0] rem;
        int         ones;
        logic       b;
        rem = 8'h00;
        ones = 0;
        for (int k = first; k < first + n; k++)
            for (int i = 15; i >= 0; i--) begin
                b = src[k][i];
                if (b) ones++;
                rem = {rem[6:0], b};
                if (rem[7]) rem = rem ^ 8'hE5;
            end
        for (int i = 0; i < 7; i++) begin
            rem = {rem[6:0], 1'b0};
            if (rem[7]) rem = rem ^ 8'hE5;
        end
        ones += $countones(rem[6:0]);
        return {rem[6:0], logic'(ones % 2)};
    endfunction

    task automatic exp_frame(input logic m, input int len);
        logic [17:0] sd;
        logic [15:0] w;
        logic [7:0]  cs;
        int          gs;
        eh.delete();
        sd = m ? 18'b10_11_00_01_11_00_10_10_10 : 18'b10_10_10_10_11_00_01_11_00;
        for (int i = 17; i >= 0; i--) eh.push_back(sd[i]);
        gs = 0;
        for (int k = 0; k < len; k++) begin
            w = src[k];
            for (int i = 15; i >= 0; i--) exp_bit(w[i]);
            if (((k + 1) % 4 == 0) || (k == len - 1)) begin
                cs = model_cs(gs, k - gs + 1);
                for (int i = 7; i >= 0; i--) exp_bit(cs[i]);
                gs = k + 1;
            end
        end
        eh.push_back(1'b0);
        eh.push_back(1'b0);
    endtask

    function automatic int first_diff();
        int n;
        n = (hv.size() < eh.size()) ? hv.size() : eh.size();
        for (int i = 0; i < n; i++)
            if (hv[i] !== eh[i]) return i;
        if (hv.size() != eh.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] rx_byte(input int h0);
        logic [7:0] r;
        if (h0 + 14 >= hv.size()) return 8'hxx;
        for (int b = 0; b < 8; b++) r[7 - b] = hv[h0 + 2 * b];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (line8 !== 1'b0) begin errors++; $display("FAIL reset_line: got %b expected 0", line8); end
        checks++;
        if (tx8 !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx8); end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++;
        if ({done8, elen8, eund8, rdy8} !== 4'b0000)
            begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {done8, elen8, eund8, rdy8}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_master_single();
        int d;
        sel4 = 1'b0; div = 8;
        src[0] = 16'h0000;
        run_frame(1'b1, 5'd1, 1);
        decode();
        exp_frame(1'b1, 1);
        checks++;
        if (timeout) begin errors++; $display("FAIL master_timeout: got timeout expected frame end"); end
        // 9 SD + 16 data + 8 CS + 1 ED bits, 16 clk each
        checks++;
        if (tx_cycles != 544) begin errors++; $display("FAIL master_tx_cycles: got %0d expected 544", tx_cycles); end
        checks++;
        if (rdy_cnt != 1) begin errors++; $display("FAIL master_ready_cnt: got %0d expected 1", rdy_cnt); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL master_done_cnt: got %0d expected 1", done_cnt); end
        checks++;
        if (und_cnt != 0) begin errors++; $display("FAIL master_underrun: got %0d expected 0", und_cnt); end
        checks++;
        if (!stable) begin errors++; $display("FAIL master_halfbit_stable: got unstable expected stable"); end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL master_line_seq: got mismatch at half %0d (%0d halves) expected none (%0d halves)", d, hv.size(), eh.size()); end
        checks++;
        if (rx_byte(50) !== 8'h00) begin errors++; $display("FAIL master_cs: got %h expected 00", rx_byte(50)); end
        checks++;
        if (end_line !== 1'b0) begin errors++; $display("FAIL master_idle_line: got %b expected 0", end_line); end
    endtask

    task automatic test_slave_five();
        int d;
        sel4 = 1'b0; div = 8;
        for (int k = 0; k < 5; k++) src[k] = 16'(k + 1);
        run_frame(1'b0, 5'd5, 5);
        decode();
        exp_frame(1'b0, 5);
        checks++;
        if (tx_cycles != 1696) begin errors++; $display("FAIL slave5_tx_cycles: got %0d expected 1696", tx_cycles); end
        checks++;
        if (rdy_cnt != 5) begin errors++; $display("FAIL slave5_ready_cnt: got %0d expected 5", rdy_cnt); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL slave5_done_cnt: got %0d expected 1", done_cnt); end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL slave5_line_seq: got mismatch at half %0d (%0d halves) expected none (%0d halves)", d, hv.size(), eh.size()); end
        checks++;
        if (rx_byte(146) !== model_cs(0, 4)) begin errors++; $display("FAIL slave5_cs1: got %h expected %h", rx_byte(146), model_cs(0, 4)); end
        checks++;
        if (rx_byte(194) !== model_cs(4, 1)) begin errors++; $display("FAIL slave5_cs2: got %h expected %h", rx_byte(194), model_cs(4, 1)); end
    endtask

    task automatic test_underrun();
        sel4 = 1'b0; div = 8;
        src[0] = 16'hA5A5;
        src[1] = 16'h5A5A;
        run_frame(1'b0, 5'd2, 1);
        checks++;
        if (timeout) begin errors++; $display("FAIL underrun_timeout: got timeout expected abort"); end
        checks++;
        if (und_cnt != 1) begin errors++; $display("FAIL underrun_pulse: got %0d expected 1", und_cnt); end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL underrun_done: got %0d expected 0", done_cnt); end
        checks++;
        if ({und_tx, und_line} !== 2'b00) begin errors++; $display("FAIL underrun_line_off: got %b expected 00", {und_tx, und_line}); end
        checks++;
        if (rdy_cnt != 1) begin errors++; $display("FAIL underrun_ready_cnt: got %0d expected 1", rdy_cnt); end
        checks++;
        if (tx_cycles != 400) begin errors++; $display("FAIL underrun_tx_cycles: got %0d expected 400", tx_cycles); end
    endtask

    task automatic test_err_len();
        logic       tm [3];
        logic [4:0] tl [3];
        bit         saw_tx;
        tm[0] = 1'b1; tl[0] = 5'd2;
        tm[1] = 1'b0; tl[1] = 5'd0;
        tm[2] = 1'b0; tl[2] = 5'd17;
        sel4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            pulse_start(tm[c], tl[c]);
            @(negedge clk);
            checks++;
            if (elen8 !== 1'b1) begin errors++; $display("FAIL err_len_pulse[%0d]: got %b expected 1", c, elen8); end
            saw_tx = tx8;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tx8 !== 1'b0) saw_tx = 1'b1;
            end
            checks++;
            if (saw_tx) begin errors++; $display("FAIL err_len_tx[%0d]: got tx_en high expected low", c); end
            checks++;
            if (busy8 !== 1'b0) begin errors++; $display("FAIL err_len_busy[%0d]: got %b expected 0", c, busy8); end
        end
    endtask

    task automatic test_reset_mid();
        int  d;
        bit  saw_tx;
        sel4 = 1'b0; div = 8;
        for (int k = 0; k < 4; k++) src[k] = 16'h1234;
        word_data = 16'h1234;
        word_valid = 1'b1;
        pulse_start(1'b0, 5'd4);
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({line8, tx8, busy8} !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 000", {line8, tx8, busy8}); end
        saw_tx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx8 !== 1'b0) saw_tx = 1'b1;
        end
        checks++;
        if (saw_tx) begin errors++; $display("FAIL rst_mid_stays_idle: got tx_en high expected low"); end
        src[0] = 16'h8001;
        run_frame(1'b1, 5'd1, 1);
        decode();
        exp_frame(1'b1, 1);
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL rst_mid_clean_seq: got mismatch at half %0d expected none", d); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL rst_mid_clean_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_clkdiv4();
        int d;
        int ones;
        sel4 = 1'b1; div = 4;
        src[0] = 16'hFFFF;
        run_frame(1'b0, 5'd1, 1);
        decode();
        exp_frame(1'b0, 1);
        checks++;
        if (tx_cycles != 272) begin errors++; $display("FAIL div4_tx_cycles: got %0d expected 272", tx_cycles); end
        checks++;
        if (!stable) begin errors++; $display("FAIL div4_halfbit_stable: got unstable expected 4-cycle half-bits"); end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL div4_line_seq: got mismatch at half %0d (%0d halves) expected none (%0d halves)", d, hv.size(), eh.size()); end
        // CRC7 of sixteen ones is 1111101, six ones plus sixteen data ones is even -> parity 0
        checks++;
        if (rx_byte(50) !== 8'hFA) begin errors++; $display("FAIL div4_cs_hand: got %h expected fa", rx_byte(50)); end
        checks++;
        if (rx_byte(50) !== model_cs(0, 1)) begin errors++; $display("FAIL div4_cs_model: got %h expected %h", rx_byte(50), model_cs(0, 1)); end
        ones = 0;
        for (int h = 18; h < 66 && h < hv.size(); h += 2) if (hv[h] === 1'b1) ones++;
        checks++;
        if ((ones % 2) != 0) begin errors++; $display("FAIL div4_even_ones: got %0d ones expected even", ones); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL div4_done: got %0d expected 1", done_cnt); end
        sel4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; master = 1'b0; len_words = '0;
        word_data = '0; word_valid = 1'b0; sel4 = 1'b0; div = 8;
        for (int k = 0; k < 16; k++) src[k] = '0;
        test_reset();
        test_master_single();
        test_slave_five();
        test_underrun();
        test_err_len();
        test_reset_mid();
        test_clkdiv4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
